// File: rtl/iris_pkg.sv
// IRIS encoder shared package: sizes, FSM states and the
// feature-bin / event-line helpers used by the encoder datapath.
package iris_pkg;

  localparam int N_FEAT        = 4;
  localparam int N_BINS        = 5;
  localparam int N_EVENT_LINES = 20;
  localparam int N_CLASSES     = 3;
  localparam int MAX_FEAT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    GAP
  } enc_state_e;

  typedef logic [2:0]               bin_t;
  typedef logic [4:0]               line_t;
  typedef logic [N_EVENT_LINES:1]   event_t;

  // (feat * 5) >> w; top bins never exceed 4 for a w-bit feature
  function automatic bin_t bin_of(
    input logic [MAX_FEAT_W-1:0] feat,
    input int unsigned           w
  );
    logic [MAX_FEAT_W+2:0] prod;
    prod = ({3'b000, feat} << 2) + {3'b000, feat};
    return bin_t'(prod >> w);
  endfunction

  // Line numbers run 1..20: feature k owns lines 5k+1..5k+5
  function automatic line_t line_of(
    input logic [1:0] k,
    input bin_t       bin
  );
    return ({3'b000, k} * 5'd5) + {2'b00, bin} + 5'd1;
  endfunction

  // Adjacent bin inside the same feature; the top bin folds down
  function automatic bin_t nb_of(input bin_t bin);
    return (bin == 3'd4) ? 3'd3 : bin + 3'd1;
  endfunction

  function automatic event_t onehot(input line_t line);
    event_t v;
    v       = '0;
    v[line] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/iris_feat_binner.sv
// IRIS feature binner: purely combinational quantiser mapping
// each packed feature onto one of five bins.
module iris_feat_binner
  import iris_pkg::*;
#(
  parameter int p_feat_width = 8
) (
  input  logic [N_FEAT*p_feat_width-1:0] i_feat,
  output bin_t [N_FEAT-1:0]              o_bin
);

  // Bin every feature in parallel
  always_comb begin
    for (int k = 0; k < N_FEAT; k++) begin
      o_bin[k] = bin_of(
        MAX_FEAT_W'(i_feat[k*p_feat_width +: p_feat_width]),
        p_feat_width
      );
    end
  end

endmodule

// File: rtl/iris_event_encoder.sv
// IRIS event encoder: sample -> one-hot event burst + silent gap.
// Optional IRIS_ENC_NEIGHBOUR_EN adds a neighbour-bin event per feature.
module iris_event_encoder
  import iris_pkg::*;
#(
  parameter int p_feat_width = 8,
  parameter int p_gap        = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [4*p_feat_width-1:0] i_feat,
  input  logic [2:0]                i_label,
  output logic [20:1]               o_event,
  output logic [2:0]                o_label,
  output logic                      o_busy,
  output logic                      o_sample_done
);

`ifdef IRIS_ENC_NEIGHBOUR_EN
  localparam int SLOT_W = 3;
`else
  localparam int SLOT_W = 2;
`endif

  localparam logic [SLOT_W-1:0] LAST_SLOT = '1;
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [7:0]        GAP_LAST  = 8'(p_gap - 1);

  enc_state_e          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [7:0]          gap_q, gap_d;
  bin_t [N_FEAT-1:0]   bins_q, bins_d, bins_in;
  logic [2:0]          label_q, label_d;
  event_t              event_q, event_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  iris_feat_binner #(
    .p_feat_width(p_feat_width)
  ) u_binner (
    .i_feat(i_feat),
    .o_bin (bins_in)
  );

  function automatic event_t slot_event(
    input logic [SLOT_W-1:0] s,
    input bin_t [N_FEAT-1:0] b
  );
`ifdef IRIS_ENC_NEIGHBOUR_EN
    logic [1:0] k;
    k = s[2:1];
    return onehot(line_of(k, s[0] ? nb_of(b[k]) : b[k]));
`else
    return onehot(line_of(s, b[s]));
`endif
  endfunction

  // Next state: accept, step through slots, then count the gap
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    bins_d  = bins_q;
    label_d = label_q;
    event_d = '0;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          state_d = EMIT;
          slot_d  = '0;
          bins_d  = bins_in;
          label_d = i_label;
          event_d = slot_event('0, bins_in);
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (slot_q == LAST_SLOT) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          slot_d  = slot_q + SLOT_ONE;
          event_d = slot_event(slot_q + SLOT_ONE, bins_q);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          label_d = '0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      gap_q   <= '0;
      bins_q  <= '0;
      label_q <= '0;
      event_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      bins_q  <= bins_d;
      label_q <= label_d;
      event_q <= event_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_event       = event_q;
  assign o_label       = label_q;
  assign o_busy        = busy_q;
  assign o_sample_done = done_q;

endmodule

// File: doc/iris_event_encoder.md
Name: iris_event_encoder

Overview:
- Upstream stage of the IRIS network. Converts one sample of 4 quantised Iris features into a serial burst of single-line events on the 20-line event bus consumed by L1 (4 features × 5 bins, one-hot per cycle).
- Carries the sample's class label alongside the events.
- Each burst is followed by a silent gap so L1/L2 time surfaces decay before the next sample.
- Replaces auto_trainer test-vector generation when samples arrive from a host/ROM.

Parameters:
p_feat_width, 8, width of each unsigned feature value
p_gap, 12, number of all-zero event cycles after each burst (legal range 1..255)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  sample present on i_feat/i_label
o_ready  out  1  encoder can accept a sample
i_feat  in  4*p_feat_width  features packed; feature k at bits [k*p_feat_width +: p_feat_width]
i_label  in  3  one-hot class label of the sample
o_event  out  20  event lines [20:1]; at most one bit high per cycle
o_label  out  3  latched label, valid while o_busy=1
o_busy  out  1  burst or gap in progress
o_sample_done  out  1  one-cycle pulse at end of gap

Behaviour:
- Clocking: one clock i_clk. Reset i_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: o_ready=1, o_event=0, o_label=0, o_busy=0, o_sample_done=0. State IDLE, counters 0.
- Bin computation, per feature: bin_k = (feat_k * 5) >> p_feat_width.
  - Product width is p_feat_width+3.
  - Result range is 0..4 for all inputs; no clamp is needed.
- Event line for feature k: line k*5 + bin_k + 1.
- Handshake: a sample is accepted on a rising edge where i_valid & o_ready. o_ready=1 only in IDLE. i_valid while busy is ignored; there is no queueing.
- On acceptance:
  - latch all 4 bins and i_label;
  - o_label <= i_label; o_busy <= 1; o_ready <= 0;
  - o_event <= one-hot for feature 0.
  - The first event is therefore visible in the cycle directly after acceptance (latency 1).
- FSM IDLE -> EMIT -> GAP -> IDLE:
  - EMIT: slot counter 0..3. Feature k's event is high for exactly one cycle, features in order 0,1,2,3 in consecutive cycles.
  - GAP: o_event=0 for p_gap cycles.
  - On the edge ending the last gap cycle: o_sample_done <= 1 (one cycle), o_busy <= 0, o_ready <= 1, o_label <= 0. State returns to IDLE.
- Back-to-back samples: if i_valid is held, the next acceptance occurs in the cycle o_ready is high. Minimum sample period is 1 + 4 + p_gap cycles.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous). The partially emitted sample is discarded and is not replayed.
- i_label is not checked for one-hot; it is passed through as-is.

Optional Feature:
- Macro IRIS_ENC_NEIGHBOUR_EN.
- Defined:
  - each feature occupies 2 EMIT cycles;
  - cycle 1 fires the primary line;
  - cycle 2 fires the neighbour bin line within the same feature: bin+1 if bin<4, else bin-1 (bin 4 -> bin 3);
  - EMIT length is 8, minimum sample period is 1 + 8 + p_gap.
- Undefined: behaviour exactly as above with EMIT length 4. No neighbour logic is synthesised.

Decomposition:
- Shared package iris_pkg holds:
  - N_FEAT=4, N_BINS=5, N_EVENT_LINES=20, N_CLASSES=3;
  - the FSM state enum (IDLE, EMIT, GAP);
  - function bin_of(feat) and function line_of(k, bin).
- One sub-module is natural: iris_feat_binner, purely combinational, 4 × (multiply-by-5 + shift). It is instantiated once, feeding the latch registers.

Test Plan:
- Reset then idle: o_ready=1, o_event=0, o_busy=0 for 10 cycles with i_valid=0.
- Single sample, feats f0=0, f1=52, f2=128, f3=255, label 3'b010:
  - o_event = bit1, bit7, bit13, bit20 on cycles +1..+4 after acceptance, then zero for 12 cycles;
  - o_label=010 throughout;
  - o_sample_done pulse at cycle +17 with o_ready=1.
- Boundary bins: f=51 -> bin 0; f=52 -> bin 1; f=255 -> bin 4.
  - All four features at 51 -> lines 1, 6, 11, 16.
  - All four at 52 -> lines 2, 7, 12, 17.
- Held i_valid with two samples: second acceptance exactly 17 cycles after the first. i_valid pulses during busy produce no extra events.
- Reset asserted at burst slot 2: outputs zero asynchronously. After release, o_ready=1 and no residual events appear.
- Macro IRIS_ENC_NEIGHBOUR_EN with feats 0/52/128/255: lines 1,2,7,8,13,14,20,19 on cycles +1..+8; o_sample_done at +21.
